// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte transmitter among NUM_REQ framed byte streams.
// One requester owns the transmitter per frame; a single holding register feeds tx_data/tx_en.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter bit INSERT_HDR = 1'b1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    input  logic                 tx_stb,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 abort,
    output logic [7:0]           err_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    state;
    logic [1:0]    gid;
    logic [1:0]    last_id;
    logic [1:0]    pick_id;
    logic [TW-1:0] timer;
    logic          load_ok;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          accept;
    logic          found;

    // The holding register may reload in the same cycle its byte is consumed.
    assign load_ok = !tx_en || tx_stb;
    assign busy    = (state != S_IDLE);
    assign accept  = (state == S_DATA) && g_valid && load_ok;

    always_comb begin
        g_valid   = 1'b0;
        g_last    = 1'b0;
        g_data    = 8'h00;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gid == 2'(i)) begin
                g_valid      = req_valid[i];
                g_last       = req_last[i];
                g_data       = req_data[8*i +: 8];
                req_ready[i] = (state == S_DATA) && load_ok;
            end
        end
    end

    // Scan starts just after the previous owner so every requester gets a turn.
    always_comb begin
        pick_id = last_id;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_id) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                pick_id = 2'(idx);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            gid       <= 2'd0;
            last_id   <= 2'(NUM_REQ - 1);
            timer     <= '0;
            tx_en     <= 1'b0;
            tx_data   <= 8'h00;
            grant     <= '0;
            abort     <= 1'b0;
            err_count <= 8'h00;
        end else begin
            abort <= 1'b0;
            if (tx_en && tx_stb)
                tx_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (found) begin
                        gid   <= pick_id;
                        grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
                        state <= INSERT_HDR ? S_HDR : S_DATA;
                    end
                end
                S_HDR: begin
                    if (load_ok) begin
                        tx_data <= {4'hA, 2'b00, gid};
                        tx_en   <= 1'b1;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        tx_data <= g_data;
                        tx_en   <= 1'b1;
                        timer   <= '0;
                        if (g_last) begin
                            state   <= S_IDLE;
                            last_id <= gid;
                            grant   <= '0;
                        end
                    end else if (!g_valid) begin
                        // Stalled owner: release the transmitter, keep whatever byte is held.
                        if (timer == TMAX) begin
                            state   <= S_IDLE;
                            last_id <= gid;
                            grant   <= '0;
                            abort   <= 1'b1;
                            timer   <= '0;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two requesters, header on, short timeout.
module tb_uart_tx_arbiter;

    typedef struct packed { logic [7:0] d; logic l; } beat_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_stb;
    logic [1:0]  grant;
    logic        busy;
    logic        abort;
    logic [7:0]  err_count;

    int vec = 0;
    int errs = 0;

    beat_t      src0_q[$];
    beat_t      src1_q[$];
    logic [7:0] exp_q[$];

    int stb_delay = 2;
    bit stb_hold = 1'b0;
    int wcnt = 0;
    bit last_cons = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(2), .INSERT_HDR(1'b1), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_en(tx_en),
        .tx_stb(tx_stb), .grant(grant), .busy(busy), .abort(abort), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Transmitter + requester model: drive at negedge, observe 1 time unit later.
    always @(negedge clk) begin
        if (stb_hold) tx_stb = 1'b0;
        else if (stb_delay == 0) tx_stb = 1'b1;
        else if (tx_en && !last_cons) begin
            wcnt++;
            tx_stb = (wcnt >= stb_delay);
        end else begin
            wcnt = 0;
            tx_stb = 1'b0;
        end
        req_valid[0]   = src0_q.size() > 0;
        req_data[7:0]  = (src0_q.size() > 0) ? src0_q[0].d : 8'h00;
        req_last[0]    = (src0_q.size() > 0) ? src0_q[0].l : 1'b0;
        req_valid[1]   = src1_q.size() > 0;
        req_data[15:8] = (src1_q.size() > 0) ? src1_q[0].d : 8'h00;
        req_last[1]    = (src1_q.size() > 0) ? src1_q[0].l : 1'b0;
        #1;
        last_cons = resetn && tx_en && tx_stb;
        if (last_cons) begin
            vec++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL tx_byte: got %02h, required no byte", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errs++;
                    $display("FAIL tx_byte: got %02h, required %02h", tx_data, e);
                end
            end
        end
        if (resetn) begin
            vec++;
            if ((req_ready & ~grant) !== 2'b00) begin
                errs++;
                $display("FAIL ready_ungranted: ready=%b grant=%b", req_ready, grant);
            end
            if (req_valid[0] && req_ready[0]) void'(src0_q.pop_front());
            if (req_valid[1] && req_ready[1]) void'(src1_q.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0) && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        vec++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
        end
        exp_q.delete(); src0_q.delete(); src1_q.delete();
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tx_stb = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        vec += 7;
        if (tx_en !== 1'b0)      begin errs++; $display("FAIL rst_tx_en: got %b, required 0", tx_en); end
        if (tx_data !== 8'h00)   begin errs++; $display("FAIL rst_tx_data: got %02h, required 00", tx_data); end
        if (grant !== 2'b00)     begin errs++; $display("FAIL rst_grant: got %b, required 00", grant); end
        if (req_ready !== 2'b00) begin errs++; $display("FAIL rst_ready: got %b, required 00", req_ready); end
        if (busy !== 1'b0)       begin errs++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (abort !== 1'b0)      begin errs++; $display("FAIL rst_abort: got %b, required 0", abort); end
        if (err_count !== 8'h00) begin errs++; $display("FAIL rst_err_count: got %0d, required 0", err_count); end
        @(negedge clk);
        resetn = 1'b1;
        #2;
    endtask

    task automatic test_single_frame();
        int cyc = 0;
        int n = 0;
        stb_delay = 10;
        src0_q.push_back('{8'h11, 1'b0});
        src0_q.push_back('{8'h22, 1'b0});
        src0_q.push_back('{8'h33, 1'b1});
        exp_q.push_back(8'hA0); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        forever begin
            @(negedge clk); #2;
            if (tx_en || cyc > 20) break;
            cyc++;
        end
        vec++;
        if (cyc !== 2) begin errs++; $display("FAIL first_tx_latency: got %0d cycles, required 2", cyc); end
        while (exp_q.size() != 0 && n < 500) begin
            if (busy) begin
                vec++;
                if (grant !== 2'b01) begin errs++; $display("FAIL frame_grant: got %b, required 01", grant); end
            end
            @(negedge clk); #2;
            n++;
        end
        wait_drain("single_frame", 10);
    endtask

    task automatic test_alternation();
        stb_delay = 3;
        do_reset();
        // last owner resets to 1, so requester 0 wins the first frame
        for (int k = 0; k < 3; k++) begin
            src0_q.push_back('{8'h40 + 8'(k), 1'b1});
            src1_q.push_back('{8'h50 + 8'(k), 1'b1});
            exp_q.push_back(8'hA0); exp_q.push_back(8'h40 + 8'(k));
            exp_q.push_back(8'hA1); exp_q.push_back(8'h50 + 8'(k));
        end
        wait_drain("alternation", 600);
    endtask

    task automatic test_stall();
        int n = 0;
        logic [7:0] held;
        stb_delay = 2;
        stb_hold = 1'b1;
        src0_q.push_back('{8'h77, 1'b0});
        src0_q.push_back('{8'h88, 1'b1});
        exp_q.push_back(8'hA0); exp_q.push_back(8'h77); exp_q.push_back(8'h88);
        while (!tx_en && n < 20) begin @(negedge clk); #2; n++; end
        held = tx_data;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #2;
            vec++;
            if (tx_en !== 1'b1 || tx_data !== held || req_ready !== 2'b00) begin
                errs++;
                $display("FAIL stall_hold: en=%b data=%02h ready=%b, required en=1 data=%02h ready=00",
                         tx_en, tx_data, req_ready, held);
            end
        end
        stb_hold = 1'b0;
        wait_drain("stall", 200);
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        int gaps = 0;
        int n = 0;
        bit started = 1'b0;
        stb_delay = 0;
        for (int k = 0; k < 8; k++) begin
            src0_q.push_back('{8'hC0 + 8'(k), (k == 7)});
        end
        exp_q.push_back(8'hA0);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'hC0 + 8'(k));
        while ((exp_q.size() != 0 || src0_q.size() != 0) && n < 100) begin
            @(negedge clk); #2;
            n++;
            if (tx_en) started = 1'b1;
            if (req_valid[0] && grant[0] && !req_ready[0]) stalls++;
            if (started && !tx_en && exp_q.size() != 0) gaps++;
        end
        vec += 2;
        if (stalls !== 1) begin errs++; $display("FAIL b2b_stalls: got %0d, required 1", stalls); end
        if (gaps !== 0)   begin errs++; $display("FAIL b2b_tx_en_gaps: got %0d, required 0", gaps); end
        wait_drain("back_to_back", 50);
        stb_delay = 2;
    endtask

    task automatic test_timeout();
        int n = 0;
        int idle_cnt = 0;
        src1_q.push_back('{8'h5A, 1'b0});
        exp_q.push_back(8'hA1); exp_q.push_back(8'h5A);
        while (grant !== 2'b10 && n < 20) begin @(negedge clk); #2; n++; end
        src0_q.push_back('{8'h61, 1'b0});
        src0_q.push_back('{8'h62, 1'b1});
        exp_q.push_back(8'hA0); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        n = 0;
        while (src1_q.size() != 0 && n < 50) begin @(negedge clk); #2; n++; end
        forever begin
            @(negedge clk); #2;
            if (grant !== 2'b10 || idle_cnt > 40) break;
            idle_cnt++;
        end
        vec += 3;
        if (idle_cnt !== 16)     begin errs++; $display("FAIL timeout_idle: got %0d cycles, required 16", idle_cnt); end
        if (abort !== 1'b1)      begin errs++; $display("FAIL timeout_abort: got %b, required 1", abort); end
        if (err_count !== 8'd1)  begin errs++; $display("FAIL timeout_err_count: got %0d, required 1", err_count); end
        @(negedge clk); #2;
        vec++;
        if (abort !== 1'b0)      begin errs++; $display("FAIL abort_pulse: got %b, required 0", abort); end
        n = 0;
        while (grant !== 2'b01 && n < 10) begin @(negedge clk); #2; n++; end
        vec++;
        if (grant !== 2'b01)     begin errs++; $display("FAIL timeout_next_grant: got %b, required 01", grant); end
        wait_drain("timeout", 200);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        stb_delay = 3;
        for (int k = 0; k < 6; k++) src0_q.push_back('{8'hD0 + 8'(k), (k == 5)});
        exp_q.push_back(8'hA0);
        for (int k = 0; k < 6; k++) exp_q.push_back(8'hD0 + 8'(k));
        while (exp_q.size() > 5 && n < 100) begin @(negedge clk); #2; n++; end
        @(negedge clk);
        resetn = 1'b0;
        // the held byte is dropped; the new frame restarts with a header
        exp_q.delete();
        exp_q.push_back(8'hA0);
        foreach (src0_q[i]) exp_q.push_back(src0_q[i].d);
        @(negedge clk);
        resetn = 1'b1;
        #2;
        vec += 5;
        if (tx_en !== 1'b0)      begin errs++; $display("FAIL mrst_tx_en: got %b, required 0", tx_en); end
        if (tx_data !== 8'h00)   begin errs++; $display("FAIL mrst_tx_data: got %02h, required 00", tx_data); end
        if (grant !== 2'b00)     begin errs++; $display("FAIL mrst_grant: got %b, required 00", grant); end
        if (busy !== 1'b0)       begin errs++; $display("FAIL mrst_busy: got %b, required 0", busy); end
        if (err_count !== 8'h00) begin errs++; $display("FAIL mrst_err_count: got %0d, required 0", err_count); end
        wait_drain("mid_reset", 300);
    endtask

    initial begin
        resetn = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; tx_stb = 1'b0;
        test_reset();
        test_single_frame();
        test_alternation();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
